// File: rtl/chip8_beeper.sv
// chip8_beeper: turns the CHIP-8 sound-timer flag into a click-free,
// volume-scaled square-wave beep on a 16-bit unsigned sample stream.
// Optional macro CHIP8_BEEPER_ENVELOPE_EN enables attack/release ramps;
// without it the tone switches straight between silence and full level.
module chip8_beeper #(
  parameter int unsigned HALF_PERIOD = 16,
  parameter logic [15:0] AMPLITUDE   = 16'h2000,
  parameter logic [15:0] RAMP_STEP   = 16'h0400
) (
  input  logic        clk_12k,
  input  logic        reset,
  input  logic        enable_in,
  input  logic [1:0]  volume,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        active
);

  localparam int PHASE_W = $clog2(2 * HALF_PERIOD);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(HALF_PERIOD);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic               sync_meta;
  logic               en_s;
  state_t             state;
  state_t             state_next;
  logic [15:0]        env;
  logic [15:0]        env_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic               wave_hi;

`ifdef CHIP8_BEEPER_ENVELOPE_EN
  logic [16:0]        env_sum;
  assign env_sum = {1'b0, env} + {1'b0, RAMP_STEP};
`else
  logic               unused_ramp;
  assign unused_ramp = ^RAMP_STEP;
`endif

  assign wave_hi = (phase < PHASE_HALF);

  // Two-flop synchronizer bringing the CPU-domain sound request into clk_12k.
  always_ff @(posedge clk_12k) begin
    if (reset) begin
      sync_meta <= 1'b0;
      en_s      <= 1'b0;
    end else begin
      sync_meta <= enable_in;
      en_s      <= sync_meta;
    end
  end

  // Next-state, envelope and phase decisions; the phase free-runs while a tone is up.
  always_comb begin
    state_next = state;
    env_next   = env;
    if (state == IDLE) begin
      phase_next = '0;
    end else if (phase == PHASE_LAST) begin
      phase_next = '0;
    end else begin
      phase_next = phase + PHASE_W'(1);
    end

    case (state)
`ifdef CHIP8_BEEPER_ENVELOPE_EN
      IDLE: begin
        env_next = '0;
        if (en_s) begin
          state_next = ATTACK;
          env_next   = RAMP_STEP;
        end
      end
      ATTACK: begin
        if (!en_s) begin
          state_next = RELEASE;
        end else if (env_sum >= {1'b0, AMPLITUDE}) begin
          state_next = SUSTAIN;
          env_next   = AMPLITUDE;
        end else begin
          env_next = env_sum[15:0];
        end
      end
      SUSTAIN: begin
        env_next = AMPLITUDE;
        if (!en_s) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (en_s) begin
          state_next = ATTACK;
        end else if (env <= RAMP_STEP) begin
          state_next = IDLE;
          env_next   = '0;
        end else begin
          env_next = env - RAMP_STEP;
        end
      end
`else
      IDLE: begin
        env_next = '0;
        if (en_s) begin
          state_next = SUSTAIN;
          env_next   = AMPLITUDE;
        end
      end
      SUSTAIN: begin
        env_next = AMPLITUDE;
        if (!en_s) begin
          state_next = IDLE;
          env_next   = '0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        env_next   = '0;
      end
    endcase
  end

  // State, envelope, phase and the active flag advance together.
  always_ff @(posedge clk_12k) begin
    if (reset) begin
      state  <= IDLE;
      env    <= '0;
      phase  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      env    <= env_next;
      phase  <= phase_next;
      active <= (state_next != IDLE);
    end
  end

  // Output sample is built from the registered envelope, phase and state.
  always_ff @(posedge clk_12k) begin
    if (reset) begin
      sample_out <= 16'h0000;
    end else if (mute || !wave_hi || (state == IDLE)) begin
      sample_out <= 16'h0000;
    end else begin
      sample_out <= env >> volume;
    end
  end

endmodule
